// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, FSM encoding and round-key storage type.
package aes_pkg;
    localparam int NR = 10;
    localparam int NK = 4;

    // Indexed by round number 1..10.
    localparam logic [10:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    typedef logic [NR:0][127:0] rk_array_t;
endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (encryption direction), one byte wide.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = TABLE[{~a, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: builds rk0..rk10 one per clock and serves rk[SelKey].
module aes_key_schedule #(
    parameter int NR           = 10,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         En,
    input  logic [127:0] CipherKey,
    input  logic [3:0]   SelKey,
    output logic [127:0] Key,
    output logic         Ry,
    output logic         Busy
);
    import aes_pkg::*;

    if (NR != 10) begin : g_bad_nr
        $error("aes_key_schedule: only NR=10 (AES-128) is supported");
    end

    ks_state_t    state;
    rk_array_t    rk;
    logic [3:0]   cnt;
    logic [127:0] prev;
    logic [31:0]  rot, sub, t;
    logic [31:0]  w0, w1, w2, w3;
    logic [127:0] next;

    assign prev = rk[cnt - 4'd1];
    assign rot  = {prev[23:0], prev[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
    end

    always_comb begin
        t    = sub ^ {RCON[cnt], 24'h0};
        w0   = prev[127:96] ^ t;
        w1   = prev[95:64]  ^ w0;
        w2   = prev[63:32]  ^ w1;
        w3   = prev[31:0]   ^ w2;
        next = {w0, w1, w2, w3};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            rk    <= '0;
            cnt   <= '0;
            Ry    <= 1'b0;
            Busy  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (En) begin
                        rk[0] <= CipherKey;
                        cnt   <= 4'd1;
                        state <= EXPAND;
                        Busy  <= 1'b1;
                        Ry    <= 1'b0;
                    end
                end
                EXPAND: begin
                    // En is deliberately ignored here: no queueing, no re-latch.
                    rk[cnt] <= next;
                    if (cnt == 4'(NR)) begin
                        state <= DONE;
                        cnt   <= '0;
                        Busy  <= 1'b0;
                        Ry    <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Partial schedules are masked so the decryptor never sees a half-built key.
    always_comb begin
        Key = '0;
        if (SelKey <= 4'(NR) && (Ry || !ZERO_INVALID))
            Key = rk[SelKey];
    end
endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Upstream neighbour of the AES-128 decryptor: expands the 128-bit cipher key into the 11 round keys (rk0..rk10) and holds them in a register file.
- Serves the round key addressed by the decryptor's SelKey[3:0] output back on its Key[127:0] input.
- Expansion is sequential, one round key per clock. Ry tells the controller the schedule is valid, and the decryptor must not be enabled until then.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported, and any other value is an elaboration error.
- ZERO_INVALID, 1, when 1 Key is driven to 128'h0 for SelKey > NR or while Ry=0; when 0 Key shows rk[SelKey] regardless.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  synchronous, active-high reset.
- En  input  1  start-expansion strobe, sampled on rising edge.
- CipherKey  input  128  cipher key; byte 0 = bits [127:120] (FIPS-197 order).
- SelKey  input  4  round-key index from the decryptor, 0..10.
- Key  output  128  selected round key, combinational read of the register file.
- Ry  output  1  high while all 11 round keys are valid.
- Busy  output  1  high while expansion is in progress.

Behaviour:
- Reset is synchronous and active-high. While Rst=1 at a rising edge: state=IDLE, rk0..rk10=0, round counter=0, Ry=0, Busy=0.
- Rst overrides En and aborts any expansion in progress; the partial schedule is discarded.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE: on En=1, latch CipherKey into rk0, set cnt=1, go to EXPAND, Busy=1.
  - EXPAND: each edge writes rk[cnt] = f(rk[cnt-1], Rcon[cnt]) and increments cnt. When cnt=10 is written, go to DONE (Busy=0, Ry=1).
  - DONE: hold the keys. En=1 restarts exactly as from IDLE; Ry drops on that same edge.
- Latency: En sampled at edge E gives Ry=1 after edge E+10, i.e. 11 cycles including the load edge.
- En while in EXPAND is ignored. No queueing, and CipherKey is not re-latched.
- CipherKey is sampled only on the load edge; later changes have no effect.
- Round function, with w0..w3 = rk[r-1] split MSB-first into 32-bit words:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - rk[r] = {w0', w1', w2', w3'}
- RotWord: {b1,b2,b3,b0}. SubWord: forward S-box applied to each byte.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Key read is zero-latency: a change on SelKey is reflected on Key in the same cycle.
  - SelKey in 11..15: Key=0 (ZERO_INVALID=1).
  - Ry=0: Key=0 (ZERO_INVALID=1). This also covers the mid-expansion case, so partially built keys never reach the decryptor.
- Only one row is written per cycle, so there are no write/read conflicts. Reading rk[SelKey] during DONE never races a write.

Decomposition:
- Package aes_pkg holds:
  - NR=10, NK=4
  - Rcon table (10 x 8-bit)
  - FSM state encoding (2-bit: IDLE=0, EXPAND=1, DONE=2)
  - round-key array typedef (11 x 128-bit)
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 4 times for SubWord.
  - Kept separate from the decryptor's inverse S-box.
- Top holds the FSM, counter, register file and read mux.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, En one cycle:
  - Ry rises exactly 11 cycles later.
  - SelKey=1 gives a0fafe1788542cb123a339392a6c7605.
  - SelKey=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - SelKey=0 returns the cipher key.
- Key 000102030405060708090a0b0c0d0e0f: SelKey=10 gives 13111d7fe3944a17f307a78b4d2b30c5.
- All-zero key:
  - SelKey=1 gives 62636363626363636263636362636363.
  - SelKey=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
- Boundaries:
  - SelKey=11 and SelKey=15 give Key=0.
  - Before Ry, Key=0 for every SelKey.
  - A second En pulse during EXPAND, with a different CipherKey on the bus, is ignored: results match the first key, and Ry timing is unchanged.
- Rst=1 at cycle 5 of EXPAND:
  - Next cycle Busy=0, Ry=0, Key=0.
  - A subsequent En completes a normal 11-cycle expansion with correct rk10.
- Re-key from DONE: En with the A.1 key after a zero-key schedule.
  - Ry drops on the load edge and returns 11 cycles later.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
